// File: rtl/etapa_mem_datos.sv
// MIPS memory-access stage: byte/halfword/word loads and stores on a word-organised
// little-endian data memory, with a sticky alignment fault and a debug read port.
module etapa_mem_datos #(
    parameter int NBITS  = 32,
    parameter int CELDAS = 32,
    parameter int ABITS  = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_Enable,
    input  logic [NBITS-1:0] i_ALU,
    input  logic [NBITS-1:0] i_DatoEscritura,
    input  logic             i_MemRead,
    input  logic             i_MemWrite,
    input  logic [1:0]       i_TamanoDato,
    input  logic             i_ExtensionSigno,
    input  logic [ABITS-1:0] i_DebugDireccion,
    output logic [NBITS-1:0] o_DatoMemoria,
    output logic             o_ErrorAlineacion,
    output logic [NBITS-1:0] o_DebugDato
);

    typedef enum logic [1:0] {
        TAM_BYTE    = 2'b00,
        TAM_MEDIA   = 2'b01,
        TAM_RES     = 2'b10,
        TAM_PALABRA = 2'b11
    } tamano_t;

    tamano_t          tamano;
    logic [NBITS-1:0] mem [CELDAS];
    logic [ABITS-1:0] indice;
    logic [1:0]       offset;
    logic             legal;
    logic [NBITS-1:0] lectura;
    logic [7:0]       byte_sel;
    logic [15:0]      media_sel;
    logic [NBITS-1:0] escritura;
    logic             unused_alu;

    assign tamano     = tamano_t'(i_TamanoDato);
    assign indice     = i_ALU[ABITS+1:2];
    assign offset     = i_ALU[1:0];
    // Address bits above the word index are ignored: accesses wrap modulo CELDAS.
    assign unused_alu = ^i_ALU[NBITS-1:ABITS+2];

    assign lectura   = mem[indice];
    assign byte_sel  = lectura[{offset, 3'b000} +: 8];
    assign media_sel = lectura[{offset[1], 4'b0000} +: 16];

    always_comb begin
        legal = 1'b0;
        case (tamano)
            TAM_BYTE:    legal = 1'b1;
            TAM_MEDIA:   legal = ~offset[0];
            TAM_PALABRA: legal = (offset == 2'b00);
            default:     legal = 1'b0;
        endcase
    end

    always_comb begin
        o_DatoMemoria = '0;
        if (i_MemRead && legal) begin
            case (tamano)
                TAM_BYTE:
                    o_DatoMemoria = {{(NBITS-8){i_ExtensionSigno & byte_sel[7]}}, byte_sel};
                TAM_MEDIA:
                    o_DatoMemoria = {{(NBITS-16){i_ExtensionSigno & media_sel[15]}}, media_sel};
                TAM_PALABRA:
                    o_DatoMemoria = lectura;
                default:
                    o_DatoMemoria = '0;
            endcase
        end
    end

    // Read-modify-write merge: untouched lanes keep the current word contents.
    always_comb begin
        escritura = lectura;
        case (tamano)
            TAM_BYTE:    escritura[{offset, 3'b000} +: 8]     = i_DatoEscritura[7:0];
            TAM_MEDIA:   escritura[{offset[1], 4'b0000} +: 16] = i_DatoEscritura[15:0];
            TAM_PALABRA: escritura = i_DatoEscritura;
            default:     escritura = lectura;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < unsigned'(CELDAS); i++) begin
                mem[ABITS'(i)] <= '0;
            end
            o_ErrorAlineacion <= 1'b0;
        end else if (i_Enable) begin
            if (i_MemWrite && legal) begin
                mem[indice] <= escritura;
            end
            if ((i_MemRead || i_MemWrite) && !legal) begin
                o_ErrorAlineacion <= 1'b1;
            end
        end
    end

    assign o_DebugDato = mem[i_DebugDireccion];

endmodule

// File: doc/etapa_mem_datos.md
# etapa_mem_datos

Memory-access stage of the 5-stage MIPS pipeline, directly upstream of the MEM/WB pipeline register. Takes the EX/MEM ALU result as a byte address and performs byte/halfword/word loads and stores on a word-organised data memory. Produces the load value that MEM/WB captures as its memory-data input, and raises a sticky alignment fault. A combinational debug read port serves the debug unit.

## Interface

Parameters:
- NBITS, 32, data/address width
- CELDAS, 32, number of 32-bit memory words (power of two)
- ABITS, 5, word-index bits, log2(CELDAS)

Ports (one clock `i_clk`; reset `i_reset` is synchronous and active-high):
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_Enable  in  1  pipeline step enable from debug unit; 0 freezes all state
- i_ALU  in  NBITS  byte address (EX/MEM ALU result)
- i_DatoEscritura  in  NBITS  store data (rt value)
- i_MemRead  in  1  load in MEM stage
- i_MemWrite  in  1  store in MEM stage
- i_TamanoDato  in  2  00 byte, 01 halfword, 11 word, 10 reserved
- i_ExtensionSigno  in  1  1 = sign-extend loads (LB/LH), 0 = zero-extend (LBU/LHU)
- i_DebugDireccion  in  ABITS  word index for debug read
- o_DatoMemoria  out  NBITS  load result, to MEM/WB
- o_ErrorAlineacion  out  1  sticky misaligned/reserved-size fault
- o_DebugDato  out  NBITS  raw word at i_DebugDireccion

## Operation

- Word index w = i_ALU[ABITS+1:2]; byte offset b = i_ALU[1:0]; bits above ABITS+1 ignored (address wraps modulo CELDAS words).
- Byte lanes little-endian: byte b occupies bits [8b+7:8b] of word w.
- Access legal iff: byte → any b; halfword → b[0]=0; word → b=00. Size 10 is always illegal.
- Store (i_MemWrite=1, i_Enable=1, legal): byte → lane b ← i_DatoEscritura[7:0]; halfword → lanes b,b+1 ← i_DatoEscritura[15:0]; word → whole word. Untouched lanes keep contents.
- Illegal store: memory unchanged.
- Load (i_MemRead=1, legal): extract selected byte/half/word; extend to NBITS with bit 7/15 when i_ExtensionSigno=1, zeros otherwise; word ignores i_ExtensionSigno.
- o_DatoMemoria = 0 when i_MemRead=0 or access illegal.
- o_ErrorAlineacion: set at the rising edge when i_Enable=1, (i_MemRead or i_MemWrite)=1 and access illegal; holds until reset.
- i_MemRead and i_MemWrite both 1: store performed; o_DatoMemoria reflects pre-edge contents until the edge, post-store contents after.
- i_Enable=0: no memory write, flag not updated; o_DatoMemoria and o_DebugDato remain live.
- o_DebugDato = mem[i_DebugDireccion], independent of all other inputs.
- Reset: all CELDAS words ← 0, o_ErrorAlineacion ← 0; reset has priority over a coincident store.

## Timing

- Reset values: memory all 0 → o_DatoMemoria = 0, o_DebugDato = 0, o_ErrorAlineacion = 0.
- Loads: zero-cycle combinational path from i_ALU/i_MemRead/i_TamanoDato/i_ExtensionSigno to o_DatoMemoria; must settle within half a cycle (MEM/WB captures on falling edge).
- Stores: committed at rising edge; visible on o_DatoMemoria/o_DebugDato immediately after that edge (load in next cycle to same address returns new data, no bubble).
- Fault flag: asserted one rising edge after the illegal access is presented.
- Reset mid-operation: store presented in the reset cycle is discarded.

## Test plan

- Reset, then i_DebugDireccion=0..31 → o_DebugDato=0 for all; o_ErrorAlineacion=0.
- Store word 0xDEADBEEF at 0x08, next cycle load word at 0x08 → o_DatoMemoria=0xDEADBEEF; o_DebugDato at index 2 = 0xDEADBEEF.
- On that word: LB at 0x0B signed → 0xFFFFFFDE; LBU at 0x0B → 0x000000DE; LH at 0x08 signed → 0xFFFFBEEF; LHU at 0x0A → 0x0000DEAD.
- SB 0x12345677 at 0x09 → word 2 = 0xDEAD77EF; SH 0xAAAA5555 at 0x0A → word 2 = 0x555577EF.
- SW at 0x0C+2 (misaligned) with value 0x11111111 → word 3 unchanged, o_DatoMemoria=0, o_ErrorAlineacion=1 next edge and stays high through later legal accesses until i_reset.
- i_Enable=0 with SW 0xCAFEF00D at 0x10 → word 4 stays 0; address 0x90 (wrap) with i_Enable=1 → writes word 4 = 0xCAFEF00D; reset asserted with coincident store → all words 0.
